// File: rtl/mult_ctrl.sv
// mult_ctrl: control unit for a shift-and-add multiplier.
// Sequences the operand loads, the accumulate step and the shift step.
// Each iteration tests the current multiplier LSB. The run ends when the
// multiplier is exhausted or all WIDTH bits have been consumed, and then
// holds done until the requester drops init.
module mult_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic lsb_b,
  input  logic z_b,
  output logic ld,
  output logic add_en,
  output logic sh,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;

  // Next-state selection; z_b wins over lsb_b so an exhausted multiplier stops at once
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = init ? START : IDLE;
      START:   next_state = CHECK;
      CHECK: begin
        if (z_b)        next_state = DONE;
        else if (lsb_b) next_state = ADD;
        else            next_state = SHIFT;
      end
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = (cnt == LAST_ITER) ? DONE : CHECK;
      DONE:    next_state = init ? DONE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, iteration counter and strobes, registered from the upcoming state
  // so each output is a clean decode of the state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ld     <= 1'b0;
      add_en <= 1'b0;
      sh     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= next_state;
      if (state == START)
        cnt <= '0;
      else if (state == SHIFT)
        cnt <= cnt + CW'(1);
      ld     <= (next_state == START);
      add_en <= (next_state == ADD);
      sh     <= (next_state == SHIFT);
      busy   <= (next_state == START) || (next_state == CHECK) ||
                (next_state == ADD)   || (next_state == SHIFT);
      done   <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: scoreboard bench for mult_ctrl.
// A small sh_r model feeds lsb_b/z_b back to the controller. Each run
// pushes its expected per-cycle strobe pattern onto a queue, and the
// pattern is popped and compared on every falling edge.
module tb_mult_ctrl;

  localparam int W = 3;

  // Output pattern order: {ld, add_en, sh, busy, done}
  localparam logic [4:0] P_IDLE  = 5'b00000;
  localparam logic [4:0] P_START = 5'b10010;
  localparam logic [4:0] P_CHECK = 5'b00010;
  localparam logic [4:0] P_ADD   = 5'b01010;
  localparam logic [4:0] P_SHIFT = 5'b00110;
  localparam logic [4:0] P_DONE  = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init = 1'b0;
  logic lsb_b;
  logic z_b;
  logic ld, add_en, sh, busy, done;

  logic [W-1:0] operand = '0;
  logic [W-1:0] sh_r = '0;

  logic [4:0] expQ[$];
  int assertCount = 0;
  int failCount = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .init   (init),
    .lsb_b  (lsb_b),
    .z_b    (z_b),
    .ld     (ld),
    .add_en (add_en),
    .sh     (sh),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Multiplier shift register model driven by the controller strobes
  always @(posedge clk) begin
    if (ld)
      sh_r <= operand;
    else if (sh)
      sh_r <= sh_r >> 1;
  end

  assign lsb_b = sh_r[0];
  assign z_b   = (sh_r == '0);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one product: builds the expected cycle pattern, then pops and compares it.
  // hold=1 keeps init high through the run and for 'extra' further DONE cycles.
  task automatic applyStimulus(input logic [W-1:0] b, input bit hold, input int extra,
                               input string name);
    logic [W-1:0] v;
    logic [4:0]   exp;
    int expAdd = 0;
    int expSh  = 0;
    int gotAdd = 0;
    int gotSh  = 0;
    int idx    = 0;
    expQ.delete();
    expQ.push_back(P_START);
    v = b;
    for (int i = 0; i < W; i++) begin
      expQ.push_back(P_CHECK);
      if (v == '0) break;
      if (v[0]) begin
        expQ.push_back(P_ADD);
        expAdd++;
      end
      expQ.push_back(P_SHIFT);
      expSh++;
      v = v >> 1;
    end
    for (int i = 0; i <= (hold ? extra : 0); i++)
      expQ.push_back(P_DONE);
    expQ.push_back(P_IDLE);

    operand = b;
    init = 1'b1;
    while (expQ.size() > 0) begin
      @(negedge clk);
      exp = expQ.pop_front();
      idx++;
      checkOutput($sformatf("%s cycle %0d", name, idx), {27'd0, ld, add_en, sh, busy, done},
                  {27'd0, exp});
      gotAdd += int'(add_en);
      gotSh  += int'(sh);
      if (!hold && idx == 1) init = 1'b0;
      if (hold && expQ.size() == 1) init = 1'b0;
    end
    checkOutput($sformatf("%s add_en pulses", name), gotAdd, expAdd);
    checkOutput($sformatf("%s sh pulses", name), gotSh, expSh);
  endtask

  initial begin
    // Reset held with init high: nothing may come out
    rst  = 1'b0;
    init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset hold %0d", i), {27'd0, ld, add_en, sh, busy, done}, 32'd0);
    end
    rst  = 1'b1;
    init = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("after reset %0d", i), {27'd0, ld, add_en, sh, busy, done}, 32'd0);
    end

    applyStimulus(3'd5, 1'b0, 0, "b5 pulse");
    applyStimulus(3'd0, 1'b0, 0, "b0 pulse");
    applyStimulus(3'd7, 1'b1, 3, "b7 held");

    // Abort during the second SHIFT of a B=5 run
    operand = 3'd5;
    init = 1'b1;
    @(negedge clk);
    checkOutput("abort start", {31'd0, ld}, 32'd1);
    init = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort second shift", {27'd0, ld, add_en, sh, busy, done}, {27'd0, P_SHIFT});
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort reset cycle", {27'd0, ld, add_en, sh, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort idle", {27'd0, ld, add_en, sh, busy, done}, 32'd0);
    applyStimulus(3'd5, 1'b0, 0, "b5 after abort");

    // Back-to-back runs with a single cycle of init low between them
    applyStimulus(3'd5, 1'b1, 0, "b2b b5");
    applyStimulus(3'd3, 1'b1, 0, "b2b b3");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Control unit for the shift-and-add multiplier. It sequences the multiplier-operand right-shift register (`sh_r`), the multiplicand left-shift register and the accumulator. It loads the operands, tests the operand LSB, adds or skips, and shifts until the multiplier is exhausted, then raises `done`. It is a Moore FSM plus an iteration counter, sitting between the top-level start request and the datapath strobes.

## Interface
- `WIDTH`, default 3: multiplier operand width (matches the 3-bit `portB`); sets the maximum number of shift iterations.
- `clk` input, 1: system clock; all state changes on the rising edge.
- `rst` input, 1: reset, synchronous, active-low. `rst`=0 at a rising edge forces the reset state.
- `init` input, 1: start request, level-sensitive, sampled in IDLE.
- `lsb_b` input, 1: bit 0 of the `sh_r` output (current multiplier LSB).
- `z_b` input, 1: 1 when the `sh_r` contents are all zero.
- `ld` output, 1: load both operands into the shift registers and clear the accumulator.
- `add_en` output, 1: accumulator ← accumulator + shifted multiplicand.
- `sh` output, 1: shift strobe; drives `init_sh_r` and the left-shift strobe.
- `busy` output, 1: high in every state except IDLE and DONE.
- `done` output, 1: product valid.

## Operation
- States: IDLE, START, CHECK, ADD, SHIFT, DONE. `cnt` is a `$clog2(WIDTH+1)`-bit iteration counter.
- Outputs are a pure decode of the state register (Moore), one-hot strobes:
  - START: `ld`=1
  - ADD: `add_en`=1
  - SHIFT: `sh`=1
  - DONE: `done`=1
  - `busy` = START | CHECK | ADD | SHIFT
- Transitions:
  - IDLE: `init`=1 → START; otherwise stay.
  - START: `cnt`←0 → CHECK.
  - CHECK: `z_b`=1 → DONE. Else `lsb_b`=1 → ADD. Else → SHIFT. CHECK asserts no strobe.
  - ADD → SHIFT, unconditionally.
  - SHIFT: `cnt`←`cnt`+1. If `cnt`==WIDTH−1 (value before increment) → DONE; else → CHECK.
  - DONE: hold `done`=1 while `init`=1. `init`=0 → IDLE. This is a four-phase handshake: the requester must drop `init` before a new product starts.
- `z_b` takes priority over `lsb_b` in CHECK. An all-zero multiplier finishes without any ADD or SHIFT.
- `cnt` never exceeds WIDTH. Wrap-around is impossible by construction, so no counter overflow handling is needed.
- Inputs `init`, `lsb_b` and `z_b` are used directly; they are registered upstream.

## Timing
- Reset: `rst`=0 at a rising edge gives state=IDLE, `cnt`=0, and `ld`=`add_en`=`sh`=`busy`=`done`=0 from the next cycle.
  - Reset applied in any state, including mid-multiplication or DONE, aborts immediately. No strobe is emitted in the cycle after reset.
- `init`=1 sampled at edge n gives `ld` high for cycle n+1 and the first CHECK in n+2.
- `sh_r` updates on the edge that ends SHIFT. The following CHECK therefore sees the post-shift `lsb_b`/`z_b`.
- Each strobe is exactly one cycle wide.
- Per iteration: 2 cycles (CHECK, SHIFT) when the LSB is 0; 3 cycles (CHECK, ADD, SHIFT) when the LSB is 1.
- Worst case, START to DONE entry, is 2 + 3·WIDTH cycles (WIDTH=3, B=7: 11 cycles).
- `init` held high through the whole run is legal. START is entered only from IDLE, and DONE persists until `init` falls.
- `init` toggled while busy is ignored.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `init`=1, then release with `init`=0 → all outputs 0, state IDLE, no `ld` pulse.
- B=5 (101), WIDTH=3, `init` pulse 1 cycle, then `init` held 0:
  - Required sequence: `ld`; CHECK; `add_en`; `sh`; CHECK; `sh`; CHECK; `add_en`; `sh`.
  - `done` rises in cycle 10 after the `init` edge and stays 1 while `init`=0 → IDLE the next cycle.
- B=0: `init`=1 → `ld`, CHECK, then `done`=1 in cycle 3. Zero `add_en` and zero `sh` pulses.
- B=7 with `init` held 1 throughout:
  - 3 `add_en` and 3 `sh` pulses; `done` entered after 11 cycles.
  - `done` stays high until `init`=0, then IDLE. There is no restart while `init` stays high in DONE.
- Reset mid-operation: assert `rst`=0 during the second SHIFT of B=5 → next cycle IDLE, all strobes 0, `cnt`=0. A fresh `init` then completes normally with the B=5 sequence.
- Back-to-back runs: B=5 then B=3 with a one-cycle `init` low between them. Pulse counts are exactly (`add_en`, `sh`) = (2,3), then (2,2) (the 3 exits via `z_b` after two shifts). `busy` is 0 in every IDLE and DONE cycle.
